// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
//   pc_state_e        : controller states (BOOT, RUN, HALT, FAULT)
//   ChipEnable/ChipDisable : levels for the instruction-memory chip enable
//   RstEnable         : asserted level of the synchronous reset
//   DEFAULT_RESET_VEC : default PC loaded on reset
//   inst_lsb_w()      : number of PC low bits that must be zero for alignment
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } pc_state_e;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;
  localparam logic RstEnable   = 1'b1;

  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  // INST_BYTES is restricted to 2 or 4, so the alignment field is 1 or 2 bits.
  function automatic int unsigned inst_lsb_w(input int unsigned inst_bytes);
    return (inst_bytes == 2) ? 1 : 2;
  endfunction

endpackage

// File: rtl/pc_gen_next_sel.sv
// Combinational next-PC selection for pc_gen.
// Picks trap, then branch (when br_en_i), then the sequential increment
// (when seq_en_i), else hold. A selected redirect whose low bits are not
// instruction-aligned raises take_fault_o instead of changing the PC.
// Ports:
//   pc_i            current PC
//   br_en_i         branch redirects are honoured in the current state
//   seq_en_i        sequential advance allowed (fetch accepted, no halt)
//   br_valid_i/br_target_i, trap_valid_i/trap_target_i  redirect requests
//   next_pc_o       PC to load if no fault
//   redirect_o      a redirect (trap or branch) was selected
//   take_fault_o    the selected redirect target is misaligned
//   fault_addr_o    the misaligned target (valid with take_fault_o)
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INST_BYTES = 4
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              br_en_i,
  input  logic              seq_en_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  output logic [ADDR_W-1:0] next_pc_o,
  output logic              redirect_o,
  output logic              take_fault_o,
  output logic [ADDR_W-1:0] fault_addr_o
);

  localparam int LSB_W = int'(inst_lsb_w(INST_BYTES));

  logic              sel;
  logic [ADDR_W-1:0] tgt;

  always_comb begin
    sel          = 1'b0;
    tgt          = '0;
    next_pc_o    = pc_i;
    take_fault_o = 1'b0;
    fault_addr_o = '0;

    if (trap_valid_i) begin
      sel = 1'b1;
      tgt = trap_target_i;
    end else if (br_en_i && br_valid_i) begin
      sel = 1'b1;
      tgt = br_target_i;
    end

    if (sel) begin
      // Only the winning redirect is checked; a dropped branch never faults.
      if (tgt[LSB_W-1:0] != '0) begin
        take_fault_o = 1'b1;
        fault_addr_o = tgt;
      end else begin
        next_pc_o = tgt;
      end
    end else if (seq_en_i) begin
      // Wraps modulo 2^ADDR_W by truncation.
      next_pc_o = pc_i + ADDR_W'(INST_BYTES);
    end
  end

  assign redirect_o = sel;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage.
// Holds the controller state and all output registers; next-PC choice is in
// pc_next_sel. Handshake: a fetch of pc_o is accepted on a posedge where
// ce_o & ready_i & ~stall_i; only then does the PC advance sequentially.
// Redirects (trap over branch) are taken regardless of ready_i/stall_i and
// appear on pc_o one cycle after the request.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pc_o, ce_o      fetch address and request valid
//   ready_i, stall_i  memory accept, pipeline hold
//   br_valid_i/br_target_i, trap_valid_i/trap_target_i  redirects
//   halt_i, resume_i  stop / restart fetching
//   fault_o, fault_addr_o  misaligned-target fault level and address
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEFAULT_RESET_VEC),
  parameter int                INST_BYTES = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  input  logic              ready_i,
  input  logic              stall_i,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              trap_valid_i,
  input  logic [ADDR_W-1:0] trap_target_i,
  input  logic              halt_i,
  input  logic              resume_i,
  output logic              fault_o,
  output logic [ADDR_W-1:0] fault_addr_o
);

  pc_state_e         state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              ce_q;
  logic              fault_q;
  logic [ADDR_W-1:0] fault_addr_q;

  logic              in_run;
  logic              seq_en;
  logic [ADDR_W-1:0] pc_d;
  logic              redirect;
  logic              take_fault;
  logic [ADDR_W-1:0] fault_addr_d;

  assign in_run = (state_q == ST_RUN);
  // Halt outranks a sequential advance, so the held PC is the next request.
  assign seq_en = in_run & ce_q & ready_i & ~stall_i & ~halt_i;

  pc_next_sel #(
    .ADDR_W     (ADDR_W),
    .INST_BYTES (INST_BYTES)
  ) u_next_sel (
    .pc_i          (pc_q),
    .br_en_i       (in_run),
    .seq_en_i      (seq_en),
    .br_valid_i    (br_valid_i),
    .br_target_i   (br_target_i),
    .trap_valid_i  (trap_valid_i),
    .trap_target_i (trap_target_i),
    .next_pc_o     (pc_d),
    .redirect_o    (redirect),
    .take_fault_o  (take_fault),
    .fault_addr_o  (fault_addr_d)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_VEC;
      ce_q         <= ChipDisable;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else if (state_q != ST_BOOT && take_fault) begin
      // Misaligned redirect from RUN/HALT/FAULT: park in FAULT, PC held.
      state_q      <= ST_FAULT;
      ce_q         <= ChipDisable;
      fault_q      <= 1'b1;
      fault_addr_q <= fault_addr_d;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_RUN;
          ce_q    <= ChipEnable;
        end
        ST_RUN: begin
          if (redirect) begin
            pc_q <= pc_d;
          end else if (halt_i) begin
            state_q <= ST_HALT;
            ce_q    <= ChipDisable;
          end else begin
            pc_q <= pc_d;
          end
        end
        ST_HALT: begin
          // Only a trap can be selected here (branches are masked).
          if (redirect) begin
            pc_q    <= pc_d;
            state_q <= ST_RUN;
            ce_q    <= ChipEnable;
          end else if (resume_i) begin
            state_q <= ST_RUN;
            ce_q    <= ChipEnable;
          end
        end
        ST_FAULT: begin
          if (redirect) begin
            pc_q    <= pc_d;
            fault_q <= 1'b0;
            state_q <= ST_RUN;
            ce_q    <= ChipEnable;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          ce_q    <= ChipDisable;
        end
      endcase
    end
  end

  assign pc_o         = pc_q;
  assign ce_o         = ce_q;
  assign fault_o      = fault_q;
  assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int AW = 16;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc_o;
  logic          ce_o;
  logic          ready_i = 1'b0;
  logic          stall_i = 1'b0;
  logic          br_valid_i = 1'b0;
  logic [AW-1:0] br_target_i = '0;
  logic          trap_valid_i = 1'b0;
  logic [AW-1:0] trap_target_i = '0;
  logic          halt_i = 1'b0;
  logic          resume_i = 1'b0;
  logic          fault_o;
  logic [AW-1:0] fault_addr_o;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(AW), .RESET_VEC(16'h0000), .INST_BYTES(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (pc_o),
    .ce_o          (ce_o),
    .ready_i       (ready_i),
    .stall_i       (stall_i),
    .br_valid_i    (br_valid_i),
    .br_target_i   (br_target_i),
    .trap_valid_i  (trap_valid_i),
    .trap_target_i (trap_target_i),
    .halt_i        (halt_i),
    .resume_i      (resume_i),
    .fault_o       (fault_o),
    .fault_addr_o  (fault_addr_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic rdy, input logic stl,
                       input logic br, input logic [AW-1:0] bt,
                       input logic tr, input logic [AW-1:0] tt,
                       input logic hlt, input logic res);
    rst = r; ready_i = rdy; stall_i = stl;
    br_valid_i = br; br_target_i = bt;
    trap_valid_i = tr; trap_target_i = tt;
    halt_i = hlt; resume_i = res;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [AW-1:0] epc, input logic ece,
                       input logic ef, input logic [AW-1:0] efa);
    checks++;
    if (pc_o !== epc || ce_o !== ece || fault_o !== ef || fault_addr_o !== efa) begin
      errors++;
      $display("FAIL %s: got pc=%h ce=%b fault=%b faddr=%h, expected pc=%h ce=%b fault=%b faddr=%h",
               name, pc_o, ce_o, fault_o, fault_addr_o, epc, ece, ef, efa);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          r, rdy, stl, br;
    logic [AW-1:0] bt;
    logic          tr;
    logic [AW-1:0] tt;
    logic          hlt, res;
    logic [AW-1:0] epc;
    logic          ece, ef;
    logic [AW-1:0] efa;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, rdy, stl, br, input logic [AW-1:0] bt,
                     input logic tr, input logic [AW-1:0] tt, input logic hlt, res,
                     input logic [AW-1:0] epc, input logic ece, ef, input logic [AW-1:0] efa);
    vec_t v;
    v.r = r; v.rdy = rdy; v.stl = stl; v.br = br; v.bt = bt; v.tr = tr; v.tt = tt;
    v.hlt = hlt; v.res = res; v.epc = epc; v.ece = ece; v.ef = ef; v.efa = efa;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  int            m_mode;
  int unsigned   m_pc, m_fa;
  bit            m_f;
  logic [2*AW+1:0] exp_q[$];

  function automatic bit misaligned(input int unsigned t);
    return (t % 4) != 0;
  endfunction

  // Applies the current inputs to the model state, as one clock edge.
  task automatic model_edge();
    int unsigned t;
    bit          have;
    have = 1'b0; t = 0;
    if (rst) begin
      m_mode = M_BOOT; m_pc = 0; m_f = 0; m_fa = 0;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else begin
      if (trap_valid_i) begin have = 1; t = trap_target_i; end
      else if (m_mode == M_RUN && br_valid_i) begin have = 1; t = br_target_i; end
      if (have && misaligned(t)) begin
        m_mode = M_FAULT; m_f = 1; m_fa = t;
      end else if (have) begin
        m_pc = t; m_f = 0; m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (halt_i) m_mode = M_HALT;
        else if (ready_i && !stall_i) m_pc = (m_pc + 4) % 65536;
      end else if (m_mode == M_HALT && resume_i) begin
        m_mode = M_RUN;
      end
    end
    exp_q.push_back({AW'(m_pc), (m_mode == M_RUN), m_f, AW'(m_fa)});
  endtask

  // ---------------- main ----------------
  initial begin
    logic [2*AW+1:0] e;
    int unsigned     t;

    //  r rdy stl br  bt       tr  tt      hlt res  epc     ce f  faddr
    add(1, 0, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0000, 0, 0, 16'h0);   // reset
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0000, 1, 0, 16'h0);   // boot -> run
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0004, 1, 0, 16'h0);
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0008, 1, 0, 16'h0);
    add(0, 0, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0008, 1, 0, 16'h0);   // not ready x3
    add(0, 0, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0008, 1, 0, 16'h0);
    add(0, 0, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0008, 1, 0, 16'h0);
    add(0, 1, 1, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0008, 1, 0, 16'h0);   // stall x3
    add(0, 1, 1, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0008, 1, 0, 16'h0);
    add(0, 1, 1, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0008, 1, 0, 16'h0);
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h000C, 1, 0, 16'h0);
    add(0, 1, 0, 1, 16'h100, 1, 16'h800, 0, 0, 16'h0800, 1, 0, 16'h0);   // trap beats branch
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0804, 1, 0, 16'h0);
    add(0, 1, 0, 1, 16'h102, 0, 16'h0,   0, 0, 16'h0804, 0, 1, 16'h102); // misaligned branch
    add(0, 1, 0, 1, 16'h100, 0, 16'h0,   0, 1, 16'h0804, 0, 1, 16'h102); // br/resume ignored
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   1, 0, 16'h0804, 0, 1, 16'h102); // halt ignored
    add(0, 1, 0, 0, 16'h0,   1, 16'h200, 0, 0, 16'h0200, 1, 0, 16'h102); // trap exits fault
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0204, 1, 0, 16'h102);
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   1, 0, 16'h0204, 0, 0, 16'h102); // halt
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0204, 0, 0, 16'h102);
    add(0, 1, 0, 1, 16'h500, 0, 16'h0,   0, 0, 16'h0204, 0, 0, 16'h102); // br ignored in halt
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 1, 16'h0204, 1, 0, 16'h102); // resume
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0208, 1, 0, 16'h102);
    add(0, 1, 0, 1, 16'h300, 0, 16'h0,   1, 0, 16'h0300, 1, 0, 16'h102); // redirect beats halt
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0304, 1, 0, 16'h102);
    add(0, 0, 1, 1, 16'h40,  0, 16'h0,   0, 0, 16'h0040, 1, 0, 16'h102); // stall+branch
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   1, 0, 16'h0040, 0, 0, 16'h102); // halt
    add(0, 1, 0, 0, 16'h0,   1, 16'h20,  0, 0, 16'h0020, 1, 0, 16'h102); // trap leaves halt
    add(0, 1, 0, 1, 16'h10,  1, 16'h803, 0, 0, 16'h0020, 0, 1, 16'h803); // misaligned trap wins
    add(0, 1, 0, 0, 16'h0,   1, 16'h801, 0, 0, 16'h0020, 0, 1, 16'h801); // update fault addr
    add(0, 1, 0, 0, 16'h0,   1, 16'h10,  0, 0, 16'h0010, 1, 0, 16'h801);
    add(1, 1, 0, 1, 16'h80,  0, 16'h0,   0, 0, 16'h0000, 0, 0, 16'h0);   // reset beats branch
    add(0, 1, 0, 0, 16'h0,   0, 16'h0,   0, 0, 16'h0000, 1, 0, 16'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].rdy, vecs[i].stl, vecs[i].br, vecs[i].bt,
            vecs[i].tr, vecs[i].tt, vecs[i].hlt, vecs[i].res);
      step();
      check($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ece, vecs[i].ef, vecs[i].efa);
    end

    // Wrap at the top of a 16-bit space.
    drive(0, 1, 0, 1, 16'hFFF8, 0, 16'h0, 0, 0); step();
    check("wrap_br", 16'hFFF8, 1, 0, 16'h0);
    drive(0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 0); step();
    check("wrap_fffc", 16'hFFFC, 1, 0, 16'h0);
    step();
    check("wrap_zero", 16'h0000, 1, 0, 16'h0);

    // Reset mid-run at 0x40 with a branch pending.
    drive(0, 1, 0, 1, 16'h40, 0, 16'h0, 0, 0); step();
    check("mid_at40", 16'h0040, 1, 0, 16'h0);
    drive(1, 1, 0, 1, 16'h60, 0, 16'h0, 0, 0); step();
    check("mid_rst", 16'h0000, 0, 0, 16'h0);
    drive(0, 1, 0, 0, 16'h0, 0, 16'h0, 0, 0); step();
    check("mid_boot", 16'h0000, 1, 0, 16'h0);
    step();
    check("mid_seq", 16'h0004, 1, 0, 16'h0);

    // Reset clears a standing fault.
    drive(0, 1, 0, 1, 16'h6, 0, 16'h0, 0, 0); step();
    check("flt_set", 16'h0004, 0, 1, 16'h6);
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0); step();
    check("flt_rst", 16'h0000, 0, 0, 16'h0);

    // Randomized run against the model; first cycle is a reset to sync.
    drive(1, 0, 0, 0, 16'h0, 0, 16'h0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      if (n != 0) begin
        rst      = ($urandom_range(0, 199) == 0);
        ready_i  = ($urandom_range(0, 3) != 0);
        stall_i  = ($urandom_range(0, 4) == 0);
        br_valid_i   = ($urandom_range(0, 9) == 0);
        trap_valid_i = ($urandom_range(0, 19) == 0);
        halt_i   = ($urandom_range(0, 19) == 0);
        resume_i = ($urandom_range(0, 3) == 0);
        t = $urandom_range(0, 65535);
        if ($urandom_range(0, 4) != 0) t = t - (t % 4);
        br_target_i = AW'(t);
        t = $urandom_range(0, 65535);
        if ($urandom_range(0, 4) != 0) t = t - (t % 4);
        trap_target_i = AW'(t);
      end
      model_edge();
      step();
      e = exp_q.pop_front();
      check($sformatf("rnd%0d", n), e[2*AW+1:AW+2], e[AW+1], e[AW], e[AW-1:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V fetch stage. It is the successor to the fixed 32-bit "increment by 4" PC register.
- Adds:
  - configurable address width, reset vector and instruction step;
  - a valid/ready fetch handshake;
  - stall;
  - branch and trap redirects with fixed priority;
  - misaligned-target fault detection;
  - a halt/resume state machine.
- Drives the instruction-memory address. Redirect and control inputs come from the execute and control stages.

Parameters:
- ADDR_W, 32, PC width in bits.
- RESET_VEC, 0, PC value loaded on reset. Must be a multiple of INST_BYTES.
- INST_BYTES, 4, sequential increment. Power of two, 2 or 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pc_o  out  ADDR_W  current fetch address
- ce_o  out  1  fetch request valid (chip enable to instruction memory)
- ready_i  in  1  instruction memory accepts pc_o this cycle
- stall_i  in  1  hold PC (pipeline back-pressure)
- br_valid_i  in  1  branch/jump redirect request
- br_target_i  in  ADDR_W  branch/jump target
- trap_valid_i  in  1  trap/exception redirect request
- trap_target_i  in  ADDR_W  trap handler address
- halt_i  in  1  request to stop fetching
- resume_i  in  1  leave HALT
- fault_o  out  1  misaligned-target fault, level
- fault_addr_o  out  ADDR_W  offending target

Behaviour:
- Reset (rst=1 at posedge) values:
  - pc_o=RESET_VEC, ce_o=0, fault_o=0, fault_addr_o=0;
  - state=BOOT.
  - Reset has priority over every other input in every state.
- States: BOOT, RUN, HALT, FAULT.
- BOOT:
  - ce_o=0.
  - Next cycle goes to RUN with pc_o=RESET_VEC unchanged.
  - This gives exactly one dead cycle after reset deassert. The first request is RESET_VEC.
- RUN:
  - ce_o=1.
  - fire = ce_o & ready_i & ~stall_i.
  - Priority at each posedge, highest first:
    1. trap_valid_i: pc_o<=trap_target_i. Accepted regardless of ready_i/stall_i.
    2. br_valid_i: pc_o<=br_target_i. Regardless of ready_i/stall_i.
    3. halt_i: go to HALT, pc_o held.
    4. fire: pc_o<=pc_o+INST_BYTES.
    5. Otherwise hold pc_o.
  - A redirect cancels any not-yet-accepted sequential address; no address is skipped or duplicated otherwise.
- Arithmetic: increment is modulo 2^ADDR_W. Max aligned address wraps to 0 with no flag.
- Misalignment check: a target is misaligned if target[log2(INST_BYTES)-1:0] != 0. It applies to the selected redirect only.
  - Misaligned branch target: go to FAULT; fault_o<=1; fault_addr_o<=br_target_i; pc_o held; ce_o=0.
  - Misaligned trap target: same, with trap_target_i.
- HALT:
  - ce_o=0, pc_o held.
  - trap_valid_i (aligned): load trap_target_i and go to RUN.
  - else resume_i: go to RUN with pc_o unchanged.
  - br_valid_i is ignored.
- FAULT:
  - ce_o=0, fault_o=1, pc_o held.
  - Only an aligned trap_valid_i exits: pc_o<=trap_target_i, fault_o<=0, go to RUN.
  - br_valid_i, resume_i and halt_i are ignored.
  - A misaligned trap in FAULT keeps FAULT and updates fault_addr_o.
- Simultaneous events:
  - trap+branch: trap wins, branch dropped.
  - redirect+halt in RUN: redirect taken; halt ignored that cycle and must be re-asserted.
  - stall+redirect: redirect taken.
- Timing: outputs are registered. pc_o/ce_o change only at posedge. Redirect latency is 1 cycle: the new target is on pc_o the cycle after request.

Decomposition:
- Shared package holds:
  - the state encoding constants (BOOT/RUN/HALT/FAULT);
  - the common ChipEnable/ChipDisable and RstEnable constants used elsewhere;
  - the default reset vector.
- One sub-module is natural: pc_next_sel. It is combinational priority select plus misalignment check, returning next_pc, take_fault and fault_addr. pc_gen keeps the state and registers.

Test Plan:
- Reset, then release, ready_i=1 -> ce_o=0 for one cycle. Then pc_o = 0x0, 0x4, 0x8, 0xC on successive cycles.
- ready_i=0 for 3 cycles at pc_o=0x8 -> pc_o holds 0x8, ce_o=1. Same result with stall_i=1.
- br_valid_i=1, target 0x100, with trap_valid_i=1, target 0x800, same cycle -> next pc_o=0x800, then 0x804.
- br_target_i=0x102 (INST_BYTES=4) -> FAULT: fault_o=1, fault_addr_o=0x102, ce_o=0. Then:
  - br_valid_i and resume_i are ignored;
  - aligned trap to 0x200 gives pc_o=0x200, fault_o=0, ce_o=1.
- ADDR_W=16, pc_o=0xFFFC, fire -> pc_o=0x0000. Also halt_i -> ce_o=0 and hold; resume_i -> continue from held pc.
- rst asserted mid-RUN at pc_o=0x40 with br_valid_i=1 -> pc_o=RESET_VEC, ce_o=0, BOOT re-entered; branch dropped.
